// File: rtl/demux_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the round-robin demux sequencer.
package demux_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StHold,
    StGap
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned num_out(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request strictly after last_i, wrapping through last_i.
module rr_pick
  import demux_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W = 3,
  localparam int unsigned NUM_OUT = num_out(SEL_W)
) (
  input  logic [NUM_OUT-1:0] req_i,
  input  logic [SEL_W-1:0]   last_i,
  output logic               any_o,
  output logic [SEL_W-1:0]   idx_o
);

  logic [NUM_OUT-1:0]   mask;
  logic [2*NUM_OUT-1:0] dbl;
  logic                 found;

  // Lower half holds requests above last; upper half is the wrapped search including last.
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(NUM_OUT); i++) begin
      mask[i] = (i > int'(last_i));
    end
    dbl = {req_i, req_i & mask};
  end

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < int'(2 * NUM_OUT); i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        idx_o = SEL_W'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/demux_rr_sequencer.sv
// Round-robin scheduler driving a shared demux tree with a setup/hold/gap sequence per grant.
module demux_rr_sequencer
  import demux_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W    = 9,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned GAP_CYC  = 1,
  localparam int unsigned NUM_OUT = num_out(SEL_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_OUT-1:0] req,
  input  logic [NUM_OUT-1:0] req_data,
  output logic [SEL_W-1:0]   demux_sel,
  output logic               demux_in,
  output logic               busy,
  output logic [SEL_W-1:0]   grant_idx,
  output logic               done,
  output logic [SEL_W-1:0]   done_idx
);

  localparam int unsigned CntW = clog2(max2(max2(HOLD_CYC, GAP_CYC), 2));
  localparam logic [CntW-1:0] HoldInit = CntW'(HOLD_CYC - 32'd1);
  localparam logic [CntW-1:0] GapInit  = CntW'((GAP_CYC > 0) ? GAP_CYC - 32'd1 : 32'd0);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic              data_q, data_d;
  logic              demux_in_q, demux_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SEL_W-1:0]  done_idx_q, done_idx_d;

  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;

  rr_pick #(
    .SEL_W(SEL_W)
  ) u_rr_pick (
    .req_i (req),
    .last_i(last_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sel_q      <= '0;
      last_q     <= '1;
      data_q     <= 1'b0;
      demux_in_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      data_q     <= data_d;
      demux_in_q <= demux_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_idx_q <= done_idx_d;
    end
  end

  // Select and latched data only move in IDLE, where demux_in is already low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (en && pick_any) begin
          sel_d   = pick_idx;
          last_d  = pick_idx;
          data_d  = req_data[pick_idx];
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d = StHold;
        cnt_d   = HoldInit;
      end
      StHold: begin
        if (cnt_q == '0) begin
          if (GAP_CYC == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            cnt_d   = GapInit;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next-state view so they align with the state they describe.
  always_comb begin
    demux_in_d = (state_d == StHold) ? data_d : 1'b0;
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StHold) && (cnt_d == '0);
    done_idx_d = done_d ? sel_d : done_idx_q;
  end

  assign demux_sel = sel_q;
  assign grant_idx = sel_q;
  assign demux_in  = demux_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_idx  = done_idx_q;

endmodule

// File: tb/tb_demux_rr_sequencer.sv
// Randomized bench for demux_rr_sequencer against a round-robin reference model.
module tb_demux_rr_sequencer;

  localparam int unsigned SEL_W    = 3;
  localparam int unsigned HOLD_CYC = 2;
  localparam int unsigned GAP_CYC  = 1;
  localparam int unsigned NUM_OUT  = 1 << SEL_W;
  localparam int          PERIOD   = 2 + HOLD_CYC + GAP_CYC;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic [NUM_OUT-1:0] req = '0;
  logic [NUM_OUT-1:0] req_data = '0;
  logic [SEL_W-1:0]   demux_sel;
  logic               demux_in;
  logic               busy;
  logic [SEL_W-1:0]   grant_idx;
  logic               done;
  logic [SEL_W-1:0]   done_idx;

  int n_checks = 0;
  int n_pass = 0;
  int m_last;
  logic [SEL_W-1:0] prev_sel;
  logic             prev_in;

  demux_rr_sequencer #(
    .SEL_W   (SEL_W),
    .HOLD_CYC(HOLD_CYC),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .req_data (req_data),
    .demux_sel(demux_sel),
    .demux_in (demux_in),
    .busy     (busy),
    .grant_idx(grant_idx),
    .done     (done),
    .done_idx (done_idx)
  );

  always #5 clk = ~clk;

  function automatic int model_pick(input logic [NUM_OUT-1:0] r, input int last);
    for (int s = 1; s <= int'(NUM_OUT); s++) begin
      int c;
      c = (last + s) % int'(NUM_OUT);
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Inputs are already set at this negedge; the pick happens on the next posedge.
  task automatic do_grant(input logic [NUM_OUT-1:0] r, input logic [NUM_OUT-1:0] d,
                          input int drop_en_k, input string tag);
    int   idx;
    logic dat;
    idx = model_pick(r, m_last);
    dat = d[idx];
    m_last = idx;
    for (int k = 1; k <= PERIOD; k++) begin
      logic eb, ei, ed;
      logic [NUM_OUT-1:0] et, ot;
      @(negedge clk);
      eb = (k < PERIOD);
      ei = (k >= 2 && k <= 1 + int'(HOLD_CYC)) ? dat : 1'b0;
      ed = (k == 1 + int'(HOLD_CYC));
      n_checks++;
      if ({busy, demux_in, done} !== {eb, ei, ed})
        $display("FAIL %s k=%0d busy/in/done got %b%b%b want %b%b%b", tag, k, busy, demux_in,
                 done, eb, ei, ed);
      else n_pass++;
      n_checks++;
      if ({demux_sel, grant_idx} !== {SEL_W'(idx), SEL_W'(idx)})
        $display("FAIL %s k=%0d sel/grant got %0d/%0d want %0d", tag, k, demux_sel, grant_idx, idx);
      else n_pass++;
      if (ed) begin
        n_checks++;
        if (done_idx !== SEL_W'(idx))
          $display("FAIL %s done_idx got %0d want %0d", tag, done_idx, idx);
        else n_pass++;
      end
      for (int i = 0; i < int'(NUM_OUT); i++) begin
        ot[i] = (int'(demux_sel) == i) ? demux_in : 1'b0;
        et[i] = (i == idx) ? ei : 1'b0;
      end
      n_checks++;
      if (ot !== et) $display("FAIL %s k=%0d tree got %b want %b", tag, k, ot, et);
      else n_pass++;
      if (demux_sel !== prev_sel) begin
        n_checks++;
        if ({demux_in, prev_in} !== 2'b00)
          $display("FAIL %s glitch sel %0d->%0d in now/prev got %b%b want 00", tag, prev_sel,
                   demux_sel, demux_in, prev_in);
        else n_pass++;
      end
      prev_sel = demux_sel;
      prev_in  = demux_in;
      if (k == drop_en_k) en = 1'b0;
    end
  endtask

  task automatic wait_idle(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, demux_in, done} !== 3'b000)
        $display("FAIL %s idle k=%0d busy/in/done got %b%b%b want 000", tag, k, busy, demux_in,
                 done);
      else n_pass++;
      prev_sel = demux_sel;
      prev_in  = demux_in;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    req = '0;
    @(negedge clk);
    n_checks++;
    if ({busy, demux_sel, demux_in, grant_idx, done, done_idx} !== '0)
      $display("FAIL reset outputs got %b%0d%b%0d%b%0d want all zero", busy, demux_sel, demux_in,
               grant_idx, done, done_idx);
    else n_pass++;
    rst_n = 1'b1;
    m_last = int'(NUM_OUT) - 1;
    prev_sel = '0;
    prev_in = 1'b0;
    wait_idle(2, "reset_en0");
  endtask

  task automatic test_lone();
    req = 8'h01;
    req_data = 8'h01;
    en = 1'b1;
    do_grant(req, req_data, 0, "lone_first");
    do_grant(req, req_data, 0, "lone_regrant");
    en = 1'b0;
  endtask

  task automatic test_all_req();
    req = 8'hFF;
    en = 1'b1;
    for (int g = 0; g < 9; g++) begin
      req_data = NUM_OUT'($urandom);
      do_grant(req, req_data, 0, "all_req");
    end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    req = 8'h10;
    req_data = NUM_OUT'($urandom);
    en = 1'b1;
    do_grant(req, req_data, 0, "wrap_set4");
    req = 8'h90;
    do_grant(req, req_data, 0, "wrap_to7");
    do_grant(req, req_data, 0, "wrap_to4");
    en = 1'b0;
  endtask

  task automatic test_random();
    en = 1'b1;
    for (int g = 0; g < 24; g++) begin
      req = ($urandom_range(0, 5) == 0) ? '0 : NUM_OUT'($urandom);
      req_data = NUM_OUT'($urandom);
      if (req == '0) wait_idle(1, "rand_noreq");
      else do_grant(req, req_data, 0, "rand");
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    req = 8'hFF;
    req_data = 8'hFF;
    en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({demux_in, busy, done} !== 3'b000)
      $display("FAIL rst_mid_hold in/busy/done got %b%b%b want 000", demux_in, busy, done);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({grant_idx, done_idx} !== '0)
      $display("FAIL rst_mid_hold grant/done_idx got %0d/%0d want 0/0", grant_idx, done_idx);
    else n_pass++;
    req = 8'h28;
    req_data = NUM_OUT'($urandom);
    rst_n = 1'b1;
    m_last = int'(NUM_OUT) - 1;
    prev_sel = '0;
    prev_in = 1'b0;
    do_grant(req, req_data, 0, "rst_first_grant");
    en = 1'b0;
  endtask

  task automatic test_backpressure();
    req = 8'h04;
    req_data = 8'h04;
    en = 1'b0;
    wait_idle(10, "bp_en0");
    en = 1'b1;
    do_grant(req, req_data, 2, "bp_drop_en");
    wait_idle(10, "bp_after");
  endtask

  initial begin
    test_reset();
    test_lone();
    test_all_req();
    test_wrap();
    test_random();
    test_reset_mid_hold();
    test_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
